// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter
//   Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
//   HI takes the remainder, LO takes the quotient. busy stalls the pipeline
//   while a divide is in flight; cancel kills it on exception or flush.
//
//   Sequence: IDLE -> CALC (WIDTH cycles) -> FIX (1) -> DONE (1) -> IDLE.
//   A new request is accepted in IDLE or DONE, so back-to-back divides
//   need no idle cycle in between.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   start       request a divide (accepted only in IDLE or DONE, cancel low)
//   signed_div  1 = DIV (two's complement), 0 = DIVU; sampled with start
//   dividend    sampled with start
//   divisor     sampled with start
//   cancel      abort the current op; no result is written
//   busy        high in CALC and FIX
//   done        one-cycle pulse; quotient/remainder valid
//   quotient    LO value, held until the next done
//   remainder   HI value, held until the next done
//
// Configuration
//   DIV_ZERO_FAST_EN : a zero divisor skips CALC and goes straight to FIX
//                      with the same result values as the full iteration.
// -----------------------------------------------------------------------------
module div_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_div,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state, state_nx, first_state;

   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rem;       // partial remainder
   logic [WIDTH-1:0] quo;       // dividend bits shifting out, quotient bits shifting in
   logic [WIDTH-1:0] dvs_mag;
   logic             neg_q;
   logic             neg_r;

   logic             accept;
   logic [WIDTH-1:0] dvd_mag_in;
   logic [WIDTH-1:0] dvs_mag_in;

   // One extra bit so the shifted remainder cannot overflow when the
   // divisor magnitude is above 2^(WIDTH-1).
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   diff;
   logic             ge;
   logic [WIDTH-1:0] rem_nx;
   logic [WIDTH-1:0] quo_nx;

   assign accept = start & ~cancel & ((state == IDLE) | (state == DONE));

   // Magnitudes fit in WIDTH unsigned bits; the most negative value maps to
   // itself, which is its exact magnitude when read as unsigned.
   assign dvd_mag_in = (signed_div & dividend[WIDTH-1]) ? -dividend : dividend;
   assign dvs_mag_in = (signed_div & divisor[WIDTH-1])  ? -divisor  : divisor;

`ifdef DIV_ZERO_FAST_EN
   logic div_zero;
   assign div_zero    = (divisor == '0);
   assign first_state = div_zero ? FIX : CALC;
`else
   assign first_state = CALC;
`endif

   // One restoring step: shift, trial subtract, keep the difference when it
   // did not borrow. A zero divisor never borrows, which yields all-ones
   // quotient and the dividend as remainder.
   assign rem_shift = {rem, quo[WIDTH-1]};
   assign diff      = rem_shift - {1'b0, dvs_mag};
   assign ge        = ~diff[WIDTH];
   assign rem_nx    = ge ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
   assign quo_nx    = {quo[WIDTH-2:0], ge};

   // NOTE: every registered signal uses non-blocking assignment so all
   // flops update together from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // NOTE: the default assignment first keeps this block free of latches
   // on paths where no case arm writes state_nx.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept) state_nx = first_state;
         CALC:    if (count == LAST) state_nx = FIX;
         FIX:     state_nx = DONE;
         DONE:    state_nx = accept ? first_state : IDLE;
         default: state_nx = IDLE;
      endcase
      // Abort wins over every other transition, including a same-cycle start.
      if (cancel) state_nx = IDLE;
   end

   // NOTE: the datapath registers are cleared on reset too, so a reset in
   // mid-operation leaves no stale operand or result visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         count     <= '0;
         rem       <= '0;
         quo       <= '0;
         dvs_mag   <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else if (accept) begin
         count   <= '0;
         rem     <= '0;
         quo     <= dvd_mag_in;
         dvs_mag <= dvs_mag_in;
         neg_q   <= signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
         neg_r   <= signed_div & dividend[WIDTH-1];
`ifdef DIV_ZERO_FAST_EN
         // Preload the values the full iteration would have produced.
         if (div_zero) begin
            quo <= '1;
            rem <= dvd_mag_in;
         end
`endif
      end else if (!cancel && state == CALC) begin
         rem   <= rem_nx;
         quo   <= quo_nx;
         count <= count + 1'b1;
      end else if (!cancel && state == FIX) begin
         // Quotient is negative when operand signs differ; remainder
         // follows the dividend sign.
         quotient  <= neg_q ? -quo : quo;
         remainder <= neg_r ? -rem : rem;
      end
   end

   assign busy = (state == CALC) | (state == FIX);
   assign done = (state == DONE);

endmodule
